insn_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Buffers fetched instruction/PC pairs so decode stalls (hazards, multi-cycle ops) do not lose instructions. Back-pressures fetch through its `stall` input, and discards all buffered entries when a jump or branch redirects the PC.

---
 rtl/insn_queue_pkg.sv | 17 +
 rtl/insn_queue_if.sv | 37 +++
 rtl/insn_queue_mem.sv | 34 +++
 rtl/insn_queue.sv | 107 ++++++++++
 tb/tb_insn_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/insn_queue_pkg.sv
// insn_queue_pkg: shared widths and the entry type for the fetch-to-decode
// instruction queue.
//   INSN_W, PC_W   : instruction and PC+4 widths
//   DEFAULT_DEPTH  : default number of queue entries
//   iq_entry_t     : one buffered {instruction, pc} pair
package insn_queue_pkg;

  localparam int unsigned INSN_W        = 32;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [INSN_W-1:0] instruction;
    logic [PC_W-1:0]   pc;
  } iq_entry_t;

endpackage

// File: rtl/insn_queue_if.sv
// insn_queue_if: fetch/decode handshake bundle of the instruction queue.
//   in_valid, in_instruction, in_pc : push side from fetch
//   flush                           : redirect, discard contents
//   stall_fetch                     : high when a push is not accepted
//   out_valid, out_instruction,
//   out_pc, out_ready               : pop side towards decode
//   count                           : occupancy 0..DEPTH
// Modports: slave = the queue, master = the fetch/decode environment.
interface insn_queue_if
  import insn_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              in_valid;
  logic [INSN_W-1:0] in_instruction;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              stall_fetch;
  logic              out_valid;
  logic [INSN_W-1:0] out_instruction;
  logic [PC_W-1:0]   out_pc;
  logic              out_ready;
  logic [PTR_W:0]    count;

  modport slave (
    input  in_valid, in_instruction, in_pc, flush, out_ready,
    output stall_fetch, out_valid, out_instruction, out_pc, count
  );

  modport master (
    output in_valid, in_instruction, in_pc, flush, out_ready,
    input  stall_fetch, out_valid, out_instruction, out_pc, count
  );

endinterface

// File: rtl/insn_queue_mem.sv
// insn_queue_mem: DEPTH x iq_entry_t register array for the instruction queue.
//   clock, reset : clock, asynchronous active-low clear of all entries
//   we, waddr, wdata : single write port
//   raddr, rdata     : asynchronous read port
module insn_queue_mem
  import insn_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  iq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output iq_entry_t        rdata
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/insn_queue.sv
// insn_queue: circular instruction/PC+4 buffer between fetch and decode.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   q (slave)    : push from fetch (in_*), stall_fetch back-pressure, flush,
//                  head towards decode (out_*), out_ready, occupancy count
// Optional feature: define INSN_QUEUE_BYPASS_EN to let an empty queue forward
// the incoming entry to decode in the same cycle.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  insn_queue_if.slave  q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic      empty, full;
  logic      bypass, bypass_take;
  logic      push, pop;
  iq_entry_t wdata, rdata, head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

`ifdef INSN_QUEUE_BYPASS_EN
  assign bypass = empty & q.in_valid & ~q.flush;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed entry taken by decode immediately is never stored.
  assign bypass_take = bypass & q.out_ready;

  // Stall depends only on registered occupancy, so a pop cannot open a slot
  // for a push in the same cycle.
  assign push = q.in_valid & ~full & ~q.flush & ~bypass_take;
  assign pop  = ~empty & q.out_ready & ~q.flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata.instruction = q.in_instruction;
  assign wdata.pc          = q.in_pc;

  insn_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    head = '0;
    if (bypass) begin
      head = wdata;
    end else if (!empty) begin
      head = rdata;
    end
  end

  assign q.out_valid       = ~q.flush & (~empty | bypass);
  assign q.out_instruction = head.instruction;
  assign q.out_pc          = head.pc;
  assign q.stall_fetch     = full;
  assign q.count           = count_q;

endmodule

// File: tb/tb_insn_queue.sv
// tb_insn_queue: directed self-checking bench for insn_queue (DEPTH = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_insn_queue;
  import insn_queue_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic mon_en;

  insn_queue_if #(.DEPTH(4)) q ();

  insn_queue #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .q     (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Occupancy must never exceed DEPTH.
  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      if (q.count > 3'd4) begin
        n_fail++;
        $display("FAIL count_bound: count=%0d, required <= 4", q.count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    q.in_valid       = 1'b0;
    q.in_instruction = '0;
    q.in_pc          = '0;
    q.flush          = 1'b0;
    q.out_ready      = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] insn, input logic [31:0] pc);
    q.in_valid       = 1'b1;
    q.in_instruction = insn;
    q.in_pc          = pc;
    step();
    q.in_valid       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    step();
    step();
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d required 0", q.count); end
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b required 0", q.out_valid); end
    n_checks++; if (q.out_instruction !== 32'h0) begin n_fail++;
      $display("FAIL reset_out_insn: got %h required 0", q.out_instruction); end
    n_checks++; if (q.out_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_out_pc: got %h required 0", q.out_pc); end
    n_checks++; if (q.stall_fetch !== 1'b0) begin n_fail++;
      $display("FAIL reset_stall: got %b required 0", q.stall_fetch); end
    reset = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    q.out_ready = 1'b0;
    push_word(32'h00A00093, 32'h4);
    n_checks++; if (q.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL single_valid: got %b required 1", q.out_valid); end
    n_checks++; if (q.out_instruction !== 32'h00A00093) begin n_fail++;
      $display("FAIL single_insn: got %h required 00a00093", q.out_instruction); end
    n_checks++; if (q.out_pc !== 32'h4) begin n_fail++;
      $display("FAIL single_pc: got %h required 4", q.out_pc); end
    n_checks++; if (q.count !== 3'd1) begin n_fail++;
      $display("FAIL single_count: got %0d required 1", q.count); end
    q.out_ready = 1'b1;
    step();
    q.out_ready = 1'b0;
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL single_drain_count: got %0d required 0", q.count); end
  endtask

  task automatic test_fill();
    q.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h11 + i, 32'h100 + 4 * i);
    n_checks++; if (q.count !== 3'd4) begin n_fail++;
      $display("FAIL fill_count: got %0d required 4", q.count); end
    n_checks++; if (q.stall_fetch !== 1'b1) begin n_fail++;
      $display("FAIL fill_stall: got %b required 1", q.stall_fetch); end
    push_word(32'h15, 32'h110);
    n_checks++; if (q.count !== 3'd4) begin n_fail++;
      $display("FAIL fill_fifth_count: got %0d required 4", q.count); end
    n_checks++; if (q.out_instruction !== 32'h11) begin n_fail++;
      $display("FAIL fill_fifth_head: got %h required 11", q.out_instruction); end
    q.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q.out_valid !== 1'b1) begin n_fail++;
        $display("FAIL drain_valid[%0d]: got %b required 1", i, q.out_valid); end
      n_checks++; if (q.out_instruction !== 32'h11 + i) begin n_fail++;
        $display("FAIL drain_insn[%0d]: got %h required %h", i, q.out_instruction,
                 32'h11 + i); end
      n_checks++; if (q.out_pc !== 32'h100 + 4 * i) begin n_fail++;
        $display("FAIL drain_pc[%0d]: got %h required %h", i, q.out_pc,
                 32'h100 + 4 * i); end
      n_checks++; if (q.stall_fetch !== (i == 0)) begin n_fail++;
        $display("FAIL drain_stall[%0d]: got %b required %b", i, q.stall_fetch, i == 0); end
      step();
    end
    q.out_ready = 1'b0;
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL drain_count: got %0d required 0", q.count); end
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL drain_empty_valid: got %b required 0", q.out_valid); end
  endtask

  task automatic test_back_to_back();
    q.out_ready = 1'b0;
    push_word(32'h20, 32'h200);
    push_word(32'h21, 32'h204);
    for (int i = 0; i < 10; i++) begin
      q.in_valid       = 1'b1;
      q.in_instruction = 32'h22 + i;
      q.in_pc          = 32'h208 + 4 * i;
      q.out_ready      = 1'b1;
      #1;
      n_checks++; if (q.out_instruction !== 32'h20 + i) begin n_fail++;
        $display("FAIL stream_insn[%0d]: got %h required %h", i, q.out_instruction,
                 32'h20 + i); end
      n_checks++; if (q.count !== 3'd2) begin n_fail++;
        $display("FAIL stream_count[%0d]: got %0d required 2", i, q.count); end
      step();
    end
    idle();
    n_checks++; if (q.count !== 3'd2) begin n_fail++;
      $display("FAIL stream_end_count: got %0d required 2", q.count); end
    q.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (q.out_instruction !== 32'h2A + i) begin n_fail++;
        $display("FAIL stream_tail_insn[%0d]: got %h required %h", i, q.out_instruction,
                 32'h2A + i); end
      n_checks++; if (q.out_pc !== 32'h228 + 4 * i) begin n_fail++;
        $display("FAIL stream_tail_pc[%0d]: got %h required %h", i, q.out_pc,
                 32'h228 + 4 * i); end
      step();
    end
    q.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    q.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h31 + i, 32'h300 + 4 * i);
    q.in_valid       = 1'b1;
    q.in_instruction = 32'h34;
    q.in_pc          = 32'h30C;
    q.out_ready      = 1'b1;
    q.flush          = 1'b1;
    #1;
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_valid: got %b required 0", q.out_valid); end
    n_checks++; if (q.stall_fetch !== 1'b0) begin n_fail++;
      $display("FAIL flush_stall: got %b required 0", q.stall_fetch); end
    step();
    idle();
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL flush_count: got %0d required 0", q.count); end
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_after_valid: got %b required 0", q.out_valid); end
    n_checks++; if (q.out_instruction !== 32'h0) begin n_fail++;
      $display("FAIL flush_after_insn: got %h required 0", q.out_instruction); end
    push_word(32'h35, 32'h400);
    n_checks++; if (q.out_instruction !== 32'h35) begin n_fail++;
      $display("FAIL flush_next_head: got %h required 35", q.out_instruction); end
    n_checks++; if (q.count !== 3'd1) begin n_fail++;
      $display("FAIL flush_next_count: got %0d required 1", q.count); end
    q.out_ready = 1'b1;
    step();
    q.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    q.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h41 + i, 32'h500 + 4 * i);
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL areset_count: got %0d required 0", q.count); end
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL areset_valid: got %b required 0", q.out_valid); end
    n_checks++; if (q.out_instruction !== 32'h0) begin n_fail++;
      $display("FAIL areset_insn: got %h required 0", q.out_instruction); end
    n_checks++; if (q.out_pc !== 32'h0) begin n_fail++;
      $display("FAIL areset_pc: got %h required 0", q.out_pc); end
    step();
    reset = 1'b1;
    step();
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL areset_release_count: got %0d required 0", q.count); end
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL areset_release_valid: got %b required 0", q.out_valid); end
  endtask

  task automatic test_bypass();
    q.in_valid       = 1'b1;
    q.in_instruction = 32'hDEADBEEF;
    q.in_pc          = 32'h80;
    q.out_ready      = 1'b1;
    #1;
`ifdef INSN_QUEUE_BYPASS_EN
    n_checks++; if (q.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL bypass_valid: got %b required 1", q.out_valid); end
    n_checks++; if (q.out_instruction !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL bypass_insn: got %h required deadbeef", q.out_instruction); end
    n_checks++; if (q.out_pc !== 32'h80) begin n_fail++;
      $display("FAIL bypass_pc: got %h required 80", q.out_pc); end
    step();
    idle();
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL bypass_count: got %0d required 0", q.count); end
`else
    n_checks++; if (q.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL nobypass_valid: got %b required 0", q.out_valid); end
    n_checks++; if (q.out_instruction !== 32'h0) begin n_fail++;
      $display("FAIL nobypass_insn: got %h required 0", q.out_instruction); end
    step();
    idle();
    n_checks++; if (q.count !== 3'd1) begin n_fail++;
      $display("FAIL nobypass_count: got %0d required 1", q.count); end
    n_checks++; if (q.out_instruction !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL nobypass_head: got %h required deadbeef", q.out_instruction); end
    q.out_ready = 1'b1;
    step();
    q.out_ready = 1'b0;
    n_checks++; if (q.count !== 3'd0) begin n_fail++;
      $display("FAIL nobypass_drain: got %0d required 0", q.count); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    idle();
    test_reset();
    test_single_push();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_bypass();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
